// File: rtl/fpu_align_shift_seq.sv
// fpu_align_shift_seq: multi-cycle mantissa align/normalise shifter, one 2^k stage per clock, with right-shift sticky.
module fpu_align_shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_data, w_shifted, w_mask;
  logic [SHW-1:0]   r_amt, r_k, w_dist;
  logic             r_left, r_sticky;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    if (!flush)
      w_next = r_state == IDLE  ? (in_valid ? (in_shamt == '0 ? DONE : SHIFT) : IDLE) :
               r_state == SHIFT ? (r_k == '0 ? DONE : SHIFT) :
               r_state == DONE  ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // Stage k moves the operand by 2^k; w_mask selects the bits a right shift drops.
  assign w_dist    = SHW'(1) << r_k;
  assign w_mask    = ~({WIDTH{1'b1}} << w_dist);
  assign w_shifted = r_left ? r_data << w_dist : r_data >> w_dist;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_data   <= '0;
      r_amt    <= '0;
      r_left   <= 1'b0;
      r_sticky <= 1'b0;
      r_k      <= '0;
    end else if (flush) begin
      r_sticky <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_data   <= in_data;
      r_amt    <= in_shamt;
      r_left   <= in_left;
      r_sticky <= 1'b0;
      r_k      <= SHW'(SHW - 1);
    end else if (r_state == SHIFT) begin
      if (r_amt[r_k]) begin
        r_data   <= w_shifted;
        r_sticky <= r_sticky | (!r_left && |(r_data & w_mask));
      end
      r_k <= r_k == '0 ? '0 : r_k - 1'b1;
    end
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == DONE;
  assign busy       = r_state != IDLE;
  assign out_data   = r_data;
  assign out_sticky = r_sticky;
endmodule

// File: tb/tb_fpu_align_shift_seq.sv
// tb_fpu_align_shift_seq: scoreboard bench for the sequential align shifter.
module tb_fpu_align_shift_seq;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  logic             clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic             in_valid = 1'b0, in_left = 1'b0, out_ready = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   in_shamt = '0;
  logic             in_ready, out_valid, out_sticky, busy;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH:0]   sb_q[$];
  int               n_vec = 0, n_err = 0;

  fpu_align_shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_left(in_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [31:0] d, input logic [4:0] s, input logic l);
    logic [63:0] m;
    if (l) return {1'b0, d << s};
    m = (64'd1 << s) - 64'd1;
    return {|(d & m[31:0]), d >> s};
  endfunction

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
      else begin
        logic [WIDTH:0] e;
        e = sb_q.pop_front();
        chk("out_data", out_data, e[WIDTH-1:0]);
        chk("out_sticky", {31'd0, out_sticky}, {31'd0, e[WIDTH]});
      end
    end

  task automatic accept(input logic [31:0] d, input logic [4:0] s, input logic l, input bit push);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_left = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    if (push) sb_q.push_back(model(d, s, l));
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i <= SHW + 3; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic run(input logic [31:0] d, input logic [4:0] s, input logic l);
    int lat;
    accept(d, s, l, 1);
    wait_out(lat);
    chk("latency", lat, s == 0 ? 32'd0 : SHW);
  endtask

  initial begin
    int lat;
    logic [31:0] held_d;
    logic        held_s;
    bit          seen;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sticky", {31'd0, out_sticky}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    run(32'h8000_0001, 5'd0, 1'b0);
    run(32'h0000_00FF, 5'd4, 1'b0);
    run(32'hF000_0000, 5'd28, 1'b0);
    run(32'h0000_0001, 5'd31, 1'b1);
    run(32'hFFFF_FFFF, 5'd31, 1'b0);
    run(32'hDEAD_BEEF, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++)
      run($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    // Backpressure: hold the result, offer a second operand that must wait.
    @(posedge clk); #1 out_ready = 1'b0;
    accept(32'h0000_00FF, 5'd4, 1'b0, 1);
    wait_out(lat);
    chk("bp_latency", lat, SHW);
    held_d = out_data; held_s = out_sticky;
    in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd8; in_left = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data_stable", out_data, held_d);
      chk("bp_sticky_stable", {31'd0, out_sticky}, {31'd0, held_s});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    sb_q.push_back(model(32'h1234_5678, 5'd8, 1'b0));
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_busy", {31'd0, busy}, 32'd1);
    wait_out(lat);
    chk("bp_second_latency", lat, SHW - 1);
    // Flush at E2 of a shamt-7 operation.
    accept(32'h0F0F_0F0F, 5'd7, 1'b0, 0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (SHW + 3) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("flush_no_valid", {31'd0, seen}, 32'd0);
    // Asynchronous reset mid-SHIFT.
    accept(32'hFFFF_FFFF, 5'd3, 1'b0, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    run(32'h0000_0F00, 5'd9, 1'b0);
    @(negedge clk);
    chk("drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_align_shift_seq.md
# fpu_align_shift_seq

Multi-cycle sequencer for FPU mantissa alignment and normalisation shifts. Accepts one operand plus a shift amount and direction over a valid/ready handshake. Applies the shift as a binary-weighted sequence of 2^k stages, one stage per clock, and accumulates a sticky bit for right shifts. A zero shift amount takes a bypass path that returns the operand unchanged. The block sits between the FPU exponent-difference / leading-zero logic and the add/normalise datapath, and replaces a wide single-cycle barrel shifter.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits
- SHW, 5, shift-amount width; WIDTH = 2^SHW

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort; discards any operation in flight
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  WIDTH  operand
- in_shamt  in  SHW  shift amount, 0..WIDTH-1
- in_left  in  1  1 = logical left shift, 0 = logical right shift with sticky
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_sticky  out  1  OR of all bits shifted out (right shifts only)
- busy  out  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Registers: data_r[WIDTH], amt_r[SHW], left_r, sticky_r, stage counter k[SHW bits, counts SHW-1 down to 0].
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load data_r = in_data, amt_r = in_shamt, left_r = in_left, sticky_r = 0, k = SHW-1.
  - If in_shamt == 0 → DONE (bypass; data unchanged). Otherwise → SHIFT.
- SHIFT: each edge processes stage k.
  - If amt_r[k] = 1: shift data_r by 2^k in direction left_r, zero-fill. For a right shift, also set sticky_r |= OR of the 2^k low bits discarded.
  - If amt_r[k] = 0: data_r is unchanged.
  - If k == 0 → DONE; otherwise decrement k.
  - All SHW stages are always walked. Latency is fixed and independent of which bits are set.
- DONE:
  - out_valid = 1; out_data = data_r; out_sticky = sticky_r.
  - On out_valid && out_ready → IDLE.
  - in_ready = 0, so an in_valid held during DONE is not accepted.
- Left shifts: sticky_r is always 0.
- Shift amounts ≥ WIDTH are not representable, so no saturation logic is needed.
- flush (synchronous, priority over all other transitions):
  - Next edge: state = IDLE, out_valid = 0, sticky_r = 0.
  - data_r keeps its value; it is unobservable while out_valid = 0.
  - An in_valid in the same cycle as flush is not accepted.
- rst (asynchronous): immediately forces IDLE, data_r = 0, amt_r = 0, sticky_r = 0, k = 0.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_sticky 0, busy 0.
- Acceptance edge E0.
- in_shamt == 0: out_valid is high from E0 onward, i.e. in the cycle immediately after the handshake cycle.
- in_shamt != 0: stages SHW-1..0 execute on edges E1..E_SHW. out_valid rises at E_SHW (E5 for SHW = 5).
- out_data and out_sticky are registered and stable while out_valid = 1 and out_ready = 0.
- Return to IDLE on the edge where out_valid && out_ready. in_ready is high the following cycle.
- No input/output overlap. Maximum throughput is one operation per SHW+2 cycles (nonzero amount) or 2 cycles (zero amount), with out_ready tied high.
- flush and out_ready in the same DONE cycle: go to IDLE; the result is considered consumed.
- rst asserted mid-SHIFT or mid-DONE: outputs take reset values asynchronously, without waiting for an edge. Operation resumes from IDLE after rst deasserts.

## Test plan
- Zero bypass: right, in_data 0x8000_0001, shamt 0 → out_valid in the cycle after acceptance; out_data 0x8000_0001, sticky 0.
- Right with sticky: in_data 0x0000_00FF, shamt 4 → out_valid at E5; out_data 0x0000_000F, out_sticky 1.
- Right exact: in_data 0xF000_0000, shamt 28 → out_data 0x0000_000F, sticky 0.
- Left maximum: in_data 0x0000_0001, shamt 31, in_left 1 → out_data 0x8000_0000, sticky 0, at E5.
- Backpressure: out_ready low for 3 cycles in DONE → out_data and out_sticky stable, in_ready 0, a second in_valid is ignored. With out_ready high, IDLE follows on the next edge and the second operand is accepted one cycle later.
- Abort: flush at E2 of a shamt 7 operation → IDLE at E3, out_valid never rises. rst pulsed mid-SHIFT → out_valid 0 and out_data 0 immediately, in_ready 1 after deassert.
